// File: rtl/ysyx_22050535_wb_arbiter_pkg.sv
// Shared widths, RV load funct3 encodings and writeback source select for the WB arbiter.
// Combinational-free package; no latency or backpressure of its own.
package ysyx_22050535_wb_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_NUM    = 1 << ADDR_WIDTH;
  localparam int LQ_DEPTH   = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_ALU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/ysyx_22050535_load_queue.sv
// In-order circular queue of {rd, funct3, offset} for outstanding loads; registered, zero-latency head.
// Push is dropped when full (caller gates on !o_full); pop is dropped when empty.
module ysyx_22050535_load_queue #(
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [AW-1:0]             i_push_rd,
  input  logic [2:0]                i_push_func,
  input  logic [1:0]                i_push_off,
  input  logic                      i_pop,
  output logic [AW-1:0]             o_head_rd,
  output logic [2:0]                o_head_func,
  output logic [1:0]                o_head_off,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [DEPTH-1:0]          o_ent_vld,
  output logic [DEPTH-1:0][AW-1:0]  o_ent_rd
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [PW:0]              r_count;
  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][AW-1:0] r_rd;
  logic [DEPTH-1:0][2:0]    r_func;
  logic [DEPTH-1:0][1:0]    r_off;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_head_rd   = r_rd[r_head];
  assign o_head_func = r_func[r_head];
  assign o_head_off  = r_off[r_head];
  assign o_ent_vld   = r_vld;
  assign o_ent_rd    = r_rd;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      r_rd    <= '0;
      r_func  <= '0;
      r_off   <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_rd[r_tail]   <= i_push_rd;
        r_func[r_tail] <= i_push_func;
        r_off[r_tail]  <= i_push_off;
        r_tail         <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22050535_wb_arbiter.sv
// Writeback arbiter: merges ALU results and in-order load responses onto the regfile write port, 1-cycle registered.
// Load responses always win and are never stalled; ALU is held off on a response or a WAW against a pending load.
module ysyx_22050535_wb_arbiter #(
  parameter int DATA_WIDTH = ysyx_22050535_wb_arbiter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ysyx_22050535_wb_arbiter_pkg::ADDR_WIDTH,
  parameter int LQ_DEPTH   = ysyx_22050535_wb_arbiter_pkg::LQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [ADDR_WIDTH-1:0] i_alu_rd,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic                  i_ld_issue_valid,
  output logic                  o_ld_issue_ready,
  input  logic [ADDR_WIDTH-1:0] i_ld_issue_rd,
  input  logic [2:0]            i_ld_issue_func,
  input  logic [1:0]            i_ld_issue_off,
  input  logic                  i_ld_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_ld_rsp_data,
  input  logic [ADDR_WIDTH-1:0] i_chk_rs1,
  input  logic [ADDR_WIDTH-1:0] i_chk_rs2,
  output logic                  o_hazard_rs1,
  output logic                  o_hazard_rs2,
  output logic                  o_wen,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_err_rsp
);

  import ysyx_22050535_wb_arbiter_pkg::*;

  logic [ADDR_WIDTH-1:0]               w_head_rd;
  logic [2:0]                          w_head_func;
  logic [1:0]                          w_head_off;
  logic                                w_lq_full;
  logic                                w_lq_empty;
  logic [LQ_DEPTH-1:0]                 w_ent_vld;
  logic [LQ_DEPTH-1:0][ADDR_WIDTH-1:0] w_ent_rd;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_alu_hit;
  logic                  w_hit_rs1;
  logic                  w_hit_rs2;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ld_result;
  wb_src_e               w_src;

  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;

  assign o_ld_issue_ready = !w_lq_full;
  assign w_push           = i_ld_issue_valid && o_ld_issue_ready;
  assign w_pop            = i_ld_rsp_valid && !w_lq_empty;

  ysyx_22050535_load_queue #(
    .AW    (ADDR_WIDTH),
    .DEPTH (LQ_DEPTH)
  ) u_load_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_rd   (i_ld_issue_rd),
    .i_push_func (i_ld_issue_func),
    .i_push_off  (i_ld_issue_off),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_func (w_head_func),
    .o_head_off  (w_head_off),
    .o_full      (w_lq_full),
    .o_empty     (w_lq_empty),
    .o_ent_vld   (w_ent_vld),
    .o_ent_rd    (w_ent_rd)
  );

  always_comb begin
    w_alu_hit = 1'b0;
    w_hit_rs1 = 1'b0;
    w_hit_rs2 = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_rd[i] == i_alu_rd))  w_alu_hit = 1'b1;
      if (w_ent_vld[i] && (w_ent_rd[i] == i_chk_rs1)) w_hit_rs1 = 1'b1;
      if (w_ent_vld[i] && (w_ent_rd[i] == i_chk_rs2)) w_hit_rs2 = 1'b1;
    end
  end

  // An ALU write to a register with an older load still in flight must wait, or the load would overwrite it.
  assign o_alu_ready = !i_ld_rsp_valid && !((i_alu_rd != '0) && w_alu_hit);

  assign o_hazard_rs1 = (i_chk_rs1 != '0) && (w_hit_rs1 || (r_wen && (r_waddr == i_chk_rs1)));
  assign o_hazard_rs2 = (i_chk_rs2 != '0) && (w_hit_rs2 || (r_wen && (r_waddr == i_chk_rs2)));

  assign w_byte = i_ld_rsp_data[{w_head_off, 3'b000} +: 8];
  assign w_half = i_ld_rsp_data[{w_head_off[1], 4'b0000} +: 16];

  always_comb begin
    w_ld_result = i_ld_rsp_data;
    case (w_head_func)
      F3_LB:   w_ld_result = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_LBU:  w_ld_result = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_LH:   w_ld_result = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_LHU:  w_ld_result = {{(DATA_WIDTH-16){1'b0}}, w_half};
      F3_LW:   w_ld_result = i_ld_rsp_data;
      default: w_ld_result = i_ld_rsp_data;
    endcase
  end

  always_comb begin
    w_src = SRC_NONE;
    if (w_pop) begin
      w_src = SRC_LOAD;
    end else if (i_alu_valid && o_alu_ready) begin
      w_src = SRC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (w_src)
        SRC_LOAD: begin
          r_wen   <= (w_head_rd != '0);
          r_waddr <= w_head_rd;
          r_wdata <= w_ld_result;
        end
        SRC_ALU: begin
          r_wen   <= (i_alu_rd != '0);
          r_waddr <= i_alu_rd;
          r_wdata <= i_alu_data;
        end
        default: r_wen <= 1'b0;
      endcase
      if (i_ld_rsp_valid && w_lq_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_wen     = r_wen;
  assign o_waddr   = r_waddr;
  assign o_wdata   = r_wdata;
  assign o_err_rsp = r_err;

endmodule

// File: doc/ysyx_22050535_wb_arbiter.md
Name: ysyx_22050535_wb_arbiter

Overview:
Writeback stage directly upstream of the register file; drives its single write port (wen/waddr/wdata).
Merges two result sources: single-cycle ALU results and in-order load responses from the LSU.
Keeps an in-order load queue of {rd, funct3, byte offset} for outstanding loads.
Uses the queue for load-data extraction/extension, RAW hazard flags to decode, and WAW ordering against the ALU.

Parameters:
DATA_WIDTH, 32, datapath width; must equal the register file data width.
ADDR_WIDTH, 5, register index width.
LQ_DEPTH, 4, maximum outstanding loads; power of two, >= 2.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous reset, active-low
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  ADDR_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
ld_issue_valid  in  1  load issued to LSU this cycle
ld_issue_ready  out  1  load queue can accept an entry
ld_issue_rd  in  ADDR_WIDTH  load destination register
ld_issue_func  in  3  RV funct3 of the load
ld_issue_off  in  2  address bits [1:0]
ld_rsp_valid  in  1  load response; no backpressure, always consumed
ld_rsp_data  in  DATA_WIDTH  raw aligned word from memory
chk_rs1, chk_rs2  in  ADDR_WIDTH  decode source registers to check
hazard_rs1, hazard_rs2  out  1  source has a pending write
wen  out  1  register file write enable
waddr  out  ADDR_WIDTH  register file write address
wdata  out  DATA_WIDTH  register file write data
err_rsp  out  1  sticky: response arrived with an empty queue

Behaviour:
- Reset (rst_n low, asynchronous): wen=0, waddr=0, wdata=0, err_rsp=0, queue empty (head=tail=count=0).
- Clock: clk. Reset is asynchronous, active-low, port rst_n.
- Load queue:
  - Push when ld_issue_valid && ld_issue_ready.
  - ld_issue_ready = (count != LQ_DEPTH). It ignores a same-cycle pop.
  - Pointers wrap modulo LQ_DEPTH.
  - Entries with rd=0 are still queued so the response is consumed.
- Response, queue non-empty: pop the head; extract and extend the result.
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: halfword at off[1], sign-extended.
  - 101 LHU: halfword at off[1], zero-extended.
  - 010 LW and any other code: raw word.
  - off[0] is ignored for halfword loads; no misalignment check.
- Response, queue empty: err_rsp set until reset; no write; queue unchanged.
- Arbitration: a load response has priority. alu_ready = !ld_rsp_valid && !(alu_rd != 0 && alu_rd matches any valid queue entry rd).
  - The WAW stall keeps an ALU write from landing before an older load to the same register.
- Output register, one-cycle latency:
  - A winning load or accepted ALU result in cycle N gives wen=1, waddr=rd, wdata=result in cycle N+1, for exactly one cycle.
  - wen is forced 0 when rd=0.
  - With no winner, wen=0 and waddr/wdata hold their old values.
- hazard_rsX = (chk_rsX != 0) && (matches any valid queue entry rd || (wen && waddr == chk_rsX)).
  - The output-register term covers the edge before the register file commits.
- Simultaneous push+pop: count unchanged and both pointers advance. Valid when full; the push is blocked only by ready.
- A push and pop of the same rd in one cycle: the new entry keeps the hazard asserted.
- Reset mid-operation: the queue is discarded. The LSU is reset together with this block, so no stale responses arrive.

Decomposition:
- Shared package/defines: DATA_WIDTH, ADDR_WIDTH, REG_NUM, and funct3 load encodings (LB/LH/LW/LBU/LHU).
- Sub-module ysyx_22050535_load_queue: parameterised circular FIFO of {rd, func, off}.
  - Outputs the head entry, full/empty, and a per-entry valid+rd vector for the comparators.
- Extraction/extension and arbitration stay in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 2 loads queued, release -> wen=0, ld_issue_ready=1, hazard_rs1=0 for chk_rs1=5 previously queued.
- ALU path: alu_valid=1, rd=3, data=0x1234 -> alu_ready=1; next cycle wen=1, waddr=3, wdata=0x1234; following cycle wen=0.
- Load extension: issue LB rd=7 off=2, then response 0x0080_FF00 -> wdata=0xFFFF_FF80. Same with LBU -> 0x0000_0080. LH off=2 on 0x8001_0000 -> 0xFFFF_8001.
- Priority/WAW:
  - Response and ALU (rd=9) in the same cycle -> alu_ready=0, load written first, ALU written the next cycle.
  - Load to rd=4 pending and ALU rd=4 -> alu_ready=0 until the response pops.
- Full/wrap: issue 4 loads -> ld_issue_ready=0. Then issue+response in the same cycle when full -> no push. Run 10 loads with interleaved responses -> in-order writes, correct rds across pointer wrap.
- Error/x0:
  - Response with an empty queue -> err_rsp=1 and sticky, wen=0.
  - Load rd=0 -> response consumed, wen=0, hazard never asserted for x0.
